instruction_fetch_unit: RTL and testbench

//  Fetch-side requester for InstructionMemory: holds the PC, drives the word-aligned

---
 rtl/instruction_fetch_unit_if.sv | 27 ++
 rtl/instruction_fetch_unit.sv | 102 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bundle between the fetch unit, InstructionMemory and decode.
// master = fetch unit, slave = memory/decode/control environment.
interface instruction_fetch_unit_if;
   logic        Enable;
   logic        Redirect;
   logic [31:0] RedirectPC;
   logic        DecodeReady;
   logic [31:0] Address;
   logic [31:0] Instruction;
   logic [31:0] InstrOut;
   logic [31:0] PCOut;
   logic [31:0] PCPlus4Out;
   logic        InstrValid;
   logic        Halted;
   logic        Fault;
   logic [15:0] FetchCount;

   modport master (
      input  Enable, Redirect, RedirectPC, DecodeReady, Instruction,
      output Address, InstrOut, PCOut, PCPlus4Out, InstrValid, Halted, Fault, FetchCount
   );

   modport slave (
      output Enable, Redirect, RedirectPC, DecodeReady, Instruction,
      input  Address, InstrOut, PCOut, PCPlus4Out, InstrValid, Halted, Fault, FetchCount
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC register, IF/ID output register with valid/ready
// handshake to decode, branch redirect, halt detection and out-of-range fault.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned MEM_WORDS  = 128,
   parameter logic [31:0] HALT_INSTR = 32'hFC00_0000
) (
   input  logic                      Clk,
   input  logic                      Reset,
   instruction_fetch_unit_if.master  bus
);

   localparam logic [32:0] PC_LIMIT = 33'(MEM_WORDS) * 33'd4;

   typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;

   state_t      state, state_n;
   logic [31:0] pc, pc_n;
   logic [31:0] instr_q, instr_n;
   logic [31:0] pc_out_q, pc_out_n;
   logic [31:0] pc4_q, pc4_n;
   logic        valid_q, valid_n;
   logic        halted_q, halted_n;
   logic        fault_q, fault_n;
   logic [15:0] count_q, count_n;

   logic        slot_free;
   logic        in_range;

   assign slot_free = !valid_q || bus.DecodeReady;
   assign in_range  = ({1'b0, pc} < PC_LIMIT);

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state    <= RUN;
         pc       <= RESET_PC;
         instr_q  <= '0;
         pc_out_q <= '0;
         pc4_q    <= '0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
         fault_q  <= 1'b0;
         count_q  <= '0;
      end else begin
         state    <= state_n;
         pc       <= pc_n;
         instr_q  <= instr_n;
         pc_out_q <= pc_out_n;
         pc4_q    <= pc4_n;
         valid_q  <= valid_n;
         halted_q <= halted_n;
         fault_q  <= fault_n;
         count_q  <= count_n;
      end
   end

   always_comb begin
      state_n  = state;
      pc_n     = pc;
      instr_n  = instr_q;
      pc_out_n = pc_out_q;
      pc4_n    = pc4_q;
      halted_n = halted_q;
      fault_n  = fault_q;
      count_n  = count_q;
      // Consumption by decode is the default; a fetch below overrides it.
      valid_n  = valid_q && !bus.DecodeReady;

      if (state == RUN) begin
         if (bus.Redirect) begin
            pc_n    = bus.RedirectPC & ~32'd3;
            valid_n = 1'b0;
         end else if (bus.Enable && slot_free) begin
            if (!in_range) begin
               fault_n = 1'b1;
               state_n = FAULT;
            end else begin
               instr_n  = bus.Instruction;
               pc_out_n = pc;
               pc4_n    = pc + 32'd4;
               valid_n  = 1'b1;
               pc_n     = pc + 32'd4;
               count_n  = (count_q == '1) ? count_q : count_q + 16'd1;
               if (bus.Instruction == HALT_INSTR) begin
                  state_n  = HALT;
                  halted_n = 1'b1;
               end
            end
         end
      end
   end

   assign bus.Address    = pc;
   assign bus.InstrOut   = instr_q;
   assign bus.PCOut      = pc_out_q;
   assign bus.PCPlus4Out = pc4_q;
   assign bus.InstrValid = valid_q;
   assign bus.Halted     = halted_q;
   assign bus.Fault      = fault_q;
   assign bus.FetchCount = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: vector table for the main flow,
// hand-written steps for fault, reset-during-stall and PC wrap.
module tb_instruction_fetch_unit;

   typedef struct {
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pcout;
      logic [31:0] pc4;
      logic [31:0] instr;
      logic        halted;
      logic        fault;
      logic [15:0] cnt;
   } exp_t;

   typedef struct {
      logic        rst;
      logic        en;
      logic        redir;
      logic [31:0] rpc;
      logic        dr;
      exp_t        e;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] mem [128];
   int          checks;
   int          errors;
   vec_t        tbl [$];

   instruction_fetch_unit_if bus ();

   instruction_fetch_unit #(
      .RESET_PC   (32'h0000_0000),
      .MEM_WORDS  (128),
      .HALT_INSTR (32'hFC00_0000)
   ) dut (
      .Clk   (clk),
      .Reset (rst_n),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational instruction memory model.
   always_comb begin
      bus.Instruction = 32'hDEAD_BEEF;
      if (bus.Address < 32'd512) bus.Instruction = mem[bus.Address[8:2]];
   end

   function automatic exp_t mk_exp(input logic [31:0] addr, input logic v,
                                   input logic [31:0] pco, input logic [31:0] pc4,
                                   input logic [31:0] ins, input logic h, input logic f,
                                   input logic [15:0] cnt);
      exp_t e;
      e.addr = addr; e.valid = v; e.pcout = pco; e.pc4 = pc4;
      e.instr = ins; e.halted = h; e.fault = f; e.cnt = cnt;
      return e;
   endfunction

   function automatic vec_t mk(input logic rst, input logic en, input logic rd,
                               input logic [31:0] rpc, input logic dr, input exp_t e);
      vec_t v;
      v.rst = rst; v.en = en; v.redir = rd; v.rpc = rpc; v.dr = dr; v.e = e;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic rst, input logic en, input logic rd,
                       input logic [31:0] rpc, input logic dr);
      rst_n           = rst;
      bus.Enable      = en;
      bus.Redirect    = rd;
      bus.RedirectPC  = rpc;
      bus.DecodeReady = dr;
      @(posedge clk);
      #1;
   endtask

   task automatic compare(input string tag, input exp_t e);
      chk({tag, ".Address"},    bus.Address,              e.addr);
      chk({tag, ".InstrValid"}, {31'd0, bus.InstrValid},  {31'd0, e.valid});
      chk({tag, ".PCOut"},      bus.PCOut,                e.pcout);
      chk({tag, ".PCPlus4Out"}, bus.PCPlus4Out,           e.pc4);
      chk({tag, ".InstrOut"},   bus.InstrOut,             e.instr);
      chk({tag, ".Halted"},     {31'd0, bus.Halted},      {31'd0, e.halted});
      chk({tag, ".Fault"},      {31'd0, bus.Fault},       {31'd0, e.fault});
      chk({tag, ".FetchCount"}, {16'd0, bus.FetchCount},  {16'd0, e.cnt});
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 128; i++) mem[i] = 32'h0000_0000;
      mem[0]   = 32'h2008_0001;
      mem[1]   = 32'h2009_0002;
      mem[2]   = 32'h0109_5020;
      mem[3]   = 32'hFC00_0000;
      mem[7]   = 32'h2222_3333;
      mem[8]   = 32'h8C0A_0004;
      mem[127] = 32'h1234_5678;

      rst_n = 1'b0; bus.Enable = 1'b0; bus.Redirect = 1'b0;
      bus.RedirectPC = '0; bus.DecodeReady = 1'b0;

      //                rst  en   rd   rpc           dr     addr   v  pcout  pc4    instr          h  f  cnt
      tbl.push_back(mk(0, 0, 0, 32'd0,        0, mk_exp(32'd0,  0, 32'd0,  32'd0,  32'h0,         0, 0, 16'd0)));
      tbl.push_back(mk(0, 0, 0, 32'd0,        0, mk_exp(32'd0,  0, 32'd0,  32'd0,  32'h0,         0, 0, 16'd0)));
      tbl.push_back(mk(1, 1, 0, 32'd0,        1, mk_exp(32'd4,  1, 32'd0,  32'd4,  32'h2008_0001, 0, 0, 16'd1)));
      tbl.push_back(mk(1, 1, 0, 32'd0,        1, mk_exp(32'd8,  1, 32'd4,  32'd8,  32'h2009_0002, 0, 0, 16'd2)));
      tbl.push_back(mk(1, 1, 0, 32'd0,        0, mk_exp(32'd8,  1, 32'd4,  32'd8,  32'h2009_0002, 0, 0, 16'd2)));
      tbl.push_back(mk(1, 1, 0, 32'd0,        0, mk_exp(32'd8,  1, 32'd4,  32'd8,  32'h2009_0002, 0, 0, 16'd2)));
      tbl.push_back(mk(1, 1, 0, 32'd0,        0, mk_exp(32'd8,  1, 32'd4,  32'd8,  32'h2009_0002, 0, 0, 16'd2)));
      tbl.push_back(mk(1, 1, 0, 32'd0,        1, mk_exp(32'd12, 1, 32'd8,  32'd12, 32'h0109_5020, 0, 0, 16'd3)));
      tbl.push_back(mk(1, 1, 1, 32'd30,       1, mk_exp(32'd28, 0, 32'd8,  32'd12, 32'h0109_5020, 0, 0, 16'd3)));
      tbl.push_back(mk(1, 1, 0, 32'd0,        1, mk_exp(32'd32, 1, 32'd28, 32'd32, 32'h2222_3333, 0, 0, 16'd4)));
      tbl.push_back(mk(1, 0, 0, 32'd0,        1, mk_exp(32'd32, 0, 32'd28, 32'd32, 32'h2222_3333, 0, 0, 16'd4)));
      tbl.push_back(mk(1, 0, 0, 32'd0,        0, mk_exp(32'd32, 0, 32'd28, 32'd32, 32'h2222_3333, 0, 0, 16'd4)));
      tbl.push_back(mk(1, 0, 1, 32'd12,       0, mk_exp(32'd12, 0, 32'd28, 32'd32, 32'h2222_3333, 0, 0, 16'd4)));
      tbl.push_back(mk(1, 1, 0, 32'd0,        0, mk_exp(32'd16, 1, 32'd12, 32'd16, 32'hFC00_0000, 1, 0, 16'd5)));
      tbl.push_back(mk(1, 1, 1, 32'd0,        0, mk_exp(32'd16, 1, 32'd12, 32'd16, 32'hFC00_0000, 1, 0, 16'd5)));
      tbl.push_back(mk(1, 1, 0, 32'd0,        1, mk_exp(32'd16, 0, 32'd12, 32'd16, 32'hFC00_0000, 1, 0, 16'd5)));
      tbl.push_back(mk(1, 1, 0, 32'd0,        1, mk_exp(32'd16, 0, 32'd12, 32'd16, 32'hFC00_0000, 1, 0, 16'd5)));
      tbl.push_back(mk(0, 1, 0, 32'd0,        1, mk_exp(32'd0,  0, 32'd0,  32'd0,  32'h0,         0, 0, 16'd0)));
      tbl.push_back(mk(1, 0, 1, 32'd12,       1, mk_exp(32'd12, 0, 32'd0,  32'd0,  32'h0,         0, 0, 16'd0)));
      tbl.push_back(mk(1, 1, 1, 32'd32,       1, mk_exp(32'd32, 0, 32'd0,  32'd0,  32'h0,         0, 0, 16'd0)));
      tbl.push_back(mk(1, 1, 0, 32'd0,        1, mk_exp(32'd36, 1, 32'd32, 32'd36, 32'h8C0A_0004, 0, 0, 16'd1)));

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rst, tbl[i].en, tbl[i].redir, tbl[i].rpc, tbl[i].dr);
         compare($sformatf("vec%0d", i), tbl[i].e);
      end

      // Last in-range word, stall at the boundary, then fault once the slot frees.
      step(1, 1, 1, 32'd508, 1);
      compare("flt_redir", mk_exp(32'd508, 0, 32'd32, 32'd36, 32'h8C0A_0004, 0, 0, 16'd1));
      step(1, 1, 0, 32'd0, 1);
      compare("flt_last", mk_exp(32'd512, 1, 32'd508, 32'd512, 32'h1234_5678, 0, 0, 16'd2));
      step(1, 1, 0, 32'd0, 0);
      compare("flt_stall", mk_exp(32'd512, 1, 32'd508, 32'd512, 32'h1234_5678, 0, 0, 16'd2));
      step(1, 1, 0, 32'd0, 1);
      compare("flt_hit", mk_exp(32'd512, 0, 32'd508, 32'd512, 32'h1234_5678, 0, 1, 16'd2));
      step(1, 1, 1, 32'd0, 1);
      compare("flt_sticky", mk_exp(32'd512, 0, 32'd508, 32'd512, 32'h1234_5678, 0, 1, 16'd2));

      // Reset while a fetched word is stalled.
      step(0, 0, 0, 32'd0, 0);
      step(1, 1, 0, 32'd0, 0);
      compare("rs_fetch", mk_exp(32'd4, 1, 32'd0, 32'd4, 32'h2008_0001, 0, 0, 16'd1));
      step(1, 1, 0, 32'd0, 0);
      compare("rs_stall", mk_exp(32'd4, 1, 32'd0, 32'd4, 32'h2008_0001, 0, 0, 16'd1));
      step(0, 1, 0, 32'd0, 0);
      compare("rs_reset", mk_exp(32'd0, 0, 32'd0, 32'd0, 32'h0, 0, 0, 16'd0));

      // Redirect target with low bits set at the top of the address space.
      step(1, 0, 1, 32'hFFFF_FFFF, 1);
      compare("wrap_redir", mk_exp(32'hFFFF_FFFC, 0, 32'd0, 32'd0, 32'h0, 0, 0, 16'd0));
      step(1, 1, 0, 32'd0, 1);
      compare("wrap_fault", mk_exp(32'hFFFF_FFFC, 0, 32'd0, 32'd0, 32'h0, 0, 1, 16'd0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
